// File: rtl/irrigation_pkg.sv
// Shared constants and types for the irrigation controller front end.
// Channel indices, default timing derived from the board clock, and per-channel status.
package irrigation_pkg;
  localparam int NUM_CH = 3;
  localparam int SOIL   = 2;
  localparam int AIR    = 1;
  localparam int TEMP   = 0;

  localparam int CLK_HZ        = 50_000_000;
  localparam int DIV_1MS       = CLK_HZ / 1_000;
  localparam int DIV_10MS      = CLK_HZ / 100;
  localparam int DIV_1S        = CLK_HZ;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = DIV_10MS;
  localparam int DEF_WINDOW_CYCLES = DIV_1S;
  localparam int DEF_CHATTER_LIMIT = 8;

  typedef struct packed {
    logic level;
    logic upd;
    logic fault;
  } ch_status_t;

  // Counter width that never collapses to zero bits for tiny parameters.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sensor_channel_filter.sv
// One sensor lane: synchroniser, persistence filter, chatter counter and sticky fault.
// Startup load and window wrap are shared strobes from the top level.
module sensor_channel_filter import irrigation_pkg::*; #(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CHATTER_LIMIT = DEF_CHATTER_LIMIT
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       raw,
  input  logic       startup_load,
  input  logic       startup_done,
  input  logic       window_wrap,
  input  logic       clear_fault,
  output ch_status_t status
);
  localparam int PW = cnt_w(STABLE_CYCLES);
  localparam int TW = $clog2(CHATTER_LIMIT + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced, synced_d, tgl, fault_set;
  logic [PW-1:0]          pcnt;
  logic [TW-1:0]          tog, tog_next;
  logic                   level, upd, fault;

  assign synced = sync_q[SYNC_STAGES-1];
  assign tgl    = synced ^ synced_d;

  // Toggle count saturates at the limit; a wrap restarts it, keeping a wrap-cycle edge.
  always_comb begin
    tog_next = tog;
    if (window_wrap)
      tog_next = TW'(tgl);
    else if (tgl && (tog != TW'(CHATTER_LIMIT)))
      tog_next = tog + TW'(1);
  end

  assign fault_set = tgl && (tog_next == TW'(CHATTER_LIMIT));

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      synced_d <= 1'b0;
      tog      <= '0;
      fault    <= 1'b0;
      pcnt     <= '0;
      level    <= 1'b0;
      upd      <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      synced_d <= synced;
      tog      <= tog_next;
      if (fault_set)        fault <= 1'b1;
      else if (clear_fault) fault <= 1'b0;
      upd <= 1'b0;
      // Faulted lanes freeze their level and keep the persistence count at zero.
      if (startup_load) begin
        level <= synced;
        pcnt  <= '0;
      end else if (!startup_done || fault || (synced == level)) begin
        pcnt <= '0;
      end else if (pcnt == PW'(STABLE_CYCLES - 1)) begin
        level <= synced;
        pcnt  <= '0;
        upd   <= 1'b1;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  assign status = '{level: level, upd: upd, fault: fault};
endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front end: three filtered channels, startup qualification and a merged change strobe.
// Holds the shared startup and chatter-window counters.
module sensor_conditioner import irrigation_pkg::*; #(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int CHATTER_LIMIT = DEF_CHATTER_LIMIT
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       soil_humidity_i,
  input  logic       air_humidity_i,
  input  logic       temperature_i,
  input  logic       clear_fault_i,
  output logic       soil_humidity_o,
  output logic       air_humidity_o,
  output logic       temperature_o,
  output logic       changed_o,
  output logic       valid_o,
  output logic [2:0] fault_o
);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int WW = cnt_w(WINDOW_CYCLES);

  logic [SW-1:0]     st_cnt;
  logic              done, load;
  logic [WW-1:0]     win_cnt;
  logic              wrap;
  logic [NUM_CH-1:0] raw, level, upd, fault;
  ch_status_t        status [NUM_CH];

  assign raw[SOIL] = soil_humidity_i;
  assign raw[AIR]  = air_humidity_i;
  assign raw[TEMP] = temperature_i;

  assign load = !done && (st_cnt == SW'(STABLE_CYCLES - 1));
  assign wrap = (win_cnt == WW'(WINDOW_CYCLES - 1));

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      st_cnt    <= '0;
      done      <= 1'b0;
      win_cnt   <= '0;
      changed_o <= 1'b0;
    end else begin
      if (load)       done   <= 1'b1;
      else if (!done) st_cnt <= st_cnt + SW'(1);
      win_cnt   <= wrap ? '0 : win_cnt + WW'(1);
      changed_o <= |upd;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sensor_channel_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CHATTER_LIMIT(CHATTER_LIMIT)
    ) u_filt (
      .clk_50mhz   (clk_50mhz),
      .rst_n       (rst_n),
      .raw         (raw[g]),
      .startup_load(load),
      .startup_done(done),
      .window_wrap (wrap),
      .clear_fault (clear_fault_i),
      .status      (status[g])
    );
    assign level[g] = status[g].level;
    assign upd[g]   = status[g].upd;
    assign fault[g] = status[g].fault;
  end

  assign soil_humidity_o = level[SOIL];
  assign air_humidity_o  = level[AIR];
  assign temperature_o   = level[TEMP];
  assign valid_o         = done;
  assign fault_o         = fault;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed scenarios and a glitch table, plus random
// stimulus, all compared against a sample-history reference model every cycle.
module tb_sensor_conditioner;
  import irrigation_pkg::*;
  localparam int SYNC = 2, STABLE = 4, WINDOW = 32, LIMIT = 3;

  logic clk_50mhz = 1'b0, rst_n = 1'b0;
  logic soil_i = 1'b1, air_i = 1'b1, temp_i = 1'b1, clr = 1'b0;
  logic soil_o, air_o, temp_o, changed_o, valid_o;
  logic [2:0] fault_o;

  always #5 clk_50mhz = ~clk_50mhz;

  sensor_conditioner #(
    .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
    .WINDOW_CYCLES(WINDOW), .CHATTER_LIMIT(LIMIT)
  ) dut (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n),
    .soil_humidity_i(soil_i), .air_humidity_i(air_i), .temperature_i(temp_i),
    .clear_fault_i(clr),
    .soil_humidity_o(soil_o), .air_humidity_o(air_o), .temperature_o(temp_o),
    .changed_o(changed_o), .valid_o(valid_o), .fault_o(fault_o)
  );

  int checks = 0, failures = 0;

  // Reference model: synced level = input sample from SYNC edges ago (queue front).
  logic [2:0] samp_q[$];
  logic [2:0] m_prev, m_filt, m_fault;
  logic       m_valid, m_changed, m_upd;
  int         m_streak[3], m_tog[3];
  int         m_wpos, m_start;
  int         wf[8];
  int         wp;

  typedef struct { int ch; int len; bit moves; } glitch_t;
  glitch_t gt[6];

  function automatic logic [7:0] obs();
    return {soil_o, air_o, temp_o, changed_o, valid_o, fault_o};
  endfunction

  function automatic logic [7:0] expv();
    return {m_filt, m_changed, m_valid, m_fault};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    repeat (SYNC) samp_q.push_back(3'b000);
    m_prev = '0; m_filt = '0; m_fault = '0;
    m_valid = 0; m_changed = 0; m_upd = 0;
    for (int c = 0; c < 3; c++) begin m_streak[c] = 0; m_tog[c] = 0; end
    m_wpos = 0; m_start = 0;
  endtask

  task automatic model_edge(input logic [2:0] raw, input logic clr_in);
    logic [2:0] syn, tg, set, nfilt;
    logic any;
    bit wrap;
    syn = samp_q[0];
    tg = syn ^ m_prev;
    wrap = (m_wpos == WINDOW - 1);
    set = '0; nfilt = m_filt; any = 0;
    for (int c = 0; c < 3; c++) begin
      m_tog[c] = wrap ? int'(tg[c]) : m_tog[c] + int'(tg[c]);
      if (tg[c] && m_tog[c] >= LIMIT) set[c] = 1'b1;
    end
    if (!m_valid) begin
      for (int c = 0; c < 3; c++) m_streak[c] = 0;
      if (m_start == STABLE - 1) begin nfilt = syn; m_valid = 1; end
      else m_start++;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (m_fault[c] || syn[c] == m_filt[c]) m_streak[c] = 0;
        else begin
          m_streak[c]++;
          if (m_streak[c] == STABLE) begin nfilt[c] = syn[c]; m_streak[c] = 0; any = 1; end
        end
      end
    end
    m_fault = set | (clr_in ? 3'b000 : m_fault);
    m_changed = m_upd;
    m_upd = any;
    m_filt = nfilt;
    m_prev = syn;
    void'(samp_q.pop_front());
    samp_q.push_back(raw);
    m_wpos = wrap ? 0 : m_wpos + 1;
  endtask

  task automatic cyc();
    @(posedge clk_50mhz);
    if (rst_n) model_edge({soil_i, air_i, temp_i}, clr);
    #1;
    check("model_cycle", obs(), expv());
  endtask

  // Run n cycles, noting the first cycle each output bit moved and counting strobes.
  task automatic watch(input int n);
    logic [7:0] o0, o;
    o0 = obs(); wp = 0;
    for (int b = 0; b < 8; b++) wf[b] = -1;
    for (int i = 1; i <= n; i++) begin
      cyc();
      o = obs();
      for (int b = 0; b < 8; b++) if (wf[b] < 0 && o[b] !== o0[b]) wf[b] = i;
      if (changed_o) wp++;
    end
  endtask

  task automatic wait_wpos(input int p);
    int k;
    k = 0;
    while (m_wpos != p && k < 2 * WINDOW) begin cyc(); k++; end
  endtask

  task automatic set_in(input int ch, input logic v);
    case (ch)
      SOIL: soil_i = v;
      AIR:  air_i = v;
      default: temp_i = v;
    endcase
  endtask

  function automatic logic get_in(input int ch);
    return (ch == SOIL) ? soil_i : (ch == AIR) ? air_i : temp_i;
  endfunction

  initial begin
    int k;
    logic lv0;
    gt[0] = '{AIR, 3, 1'b0};
    gt[1] = '{TEMP, 1, 1'b0};
    gt[2] = '{SOIL, 2, 1'b0};
    gt[3] = '{SOIL, 3, 1'b0};
    gt[4] = '{AIR, 4, 1'b1};
    gt[5] = '{TEMP, 6, 1'b1};

    // Reset with all inputs high, then release.
    model_reset();
    #2;
    check("reset_outs", obs(), 8'h00);
    repeat (3) cyc();
    check("reset_outs_held", obs(), 8'h00);
    rst_n = 1'b1;
    watch(10);
    check("valid_latency", wf[3], 4);
    check("startup_levels", {soil_o, air_o, temp_o}, 3'b111);
    check("startup_no_strobe", wp, 0);

    // All three fall together: one strobe, outputs move 6 cycles after the edge.
    wait_wpos(1);
    soil_i = 0; air_i = 0; temp_i = 0;
    watch(12);
    check("fall_soil_lat", wf[7], 6);
    check("fall_air_lat", wf[6], 6);
    check("fall_temp_lat", wf[5], 6);
    check("fall_strobe_cnt", wp, 1);

    // Soil rise alone.
    wait_wpos(1);
    soil_i = 1;
    watch(12);
    check("soil_rise_lat", wf[7], 6);
    check("soil_strobe_at", wf[4], 7);
    check("soil_strobe_cnt", wp, 1);
    check("soil_rise_air_still", wf[6], 32'hffffffff);

    // Glitch table: pulses shorter than STABLE never reach the output.
    for (int g = 0; g < 6; g++) begin
      wait_wpos(1);
      lv0 = get_in(gt[g].ch);
      set_in(gt[g].ch, !lv0);
      repeat (gt[g].len) cyc();
      set_in(gt[g].ch, lv0);
      watch(16);
      check($sformatf("glitch%0d_moved", g), (wf[5 + gt[g].ch] >= 0), gt[g].moves);
      check($sformatf("glitch%0d_strobes", g), wp, gt[g].moves ? 2 : 0);
      check($sformatf("glitch%0d_final", g), obs() >> (5 + gt[g].ch) & 8'h1, lv0);
    end

    // Temperature chatter: third toggle raises the fault, level freezes, clear resumes.
    wait_wpos(1);
    temp_i = 1; cyc(); cyc();
    temp_i = 0; cyc(); cyc();
    temp_i = 1;
    watch(8);
    check("chatter_fault_lat", wf[0], 3);
    check("chatter_fault", fault_o, 3'b001);
    check("chatter_temp_held", temp_o, 1'b0);
    repeat (10) cyc();
    check("temp_frozen", temp_o, 1'b0);
    clr = 1; cyc(); clr = 0;
    check("fault_cleared", fault_o, 3'b000);
    watch(8);
    check("temp_resume_lat", wf[5], 4);
    check("temp_resumed", temp_o, 1'b1);

    // Soil and air move in the same cycle: single strobe.
    wait_wpos(1);
    soil_i = 0; air_i = 1;
    watch(12);
    check("dual_soil_lat", wf[7], 6);
    check("dual_air_lat", wf[6], 6);
    check("dual_strobe_cnt", wp, 1);

    // Random stimulus with occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9) == 0) soil_i = !soil_i;
      if ($urandom_range(9) == 0) air_i = !air_i;
      if ($urandom_range(11) == 0) temp_i = !temp_i;
      clr = ($urandom_range(39) == 0);
      if ($urandom_range(299) == 0) begin
        rst_n = 0; model_reset(); #1;
        check("rand_reset_outs", obs(), 8'h00);
        cyc(); cyc();
        rst_n = 1;
      end
      cyc();
    end
    clr = 0;

    // Reset in the middle of a persistence count.
    k = 0;
    while (!m_valid && k < 20) begin cyc(); k++; end
    check("valid_before_reset", valid_o, 1'b1);
    soil_i = !soil_i;
    repeat (3) cyc();
    rst_n = 0; model_reset(); #1;
    check("midreset_outs", obs(), 8'h00);
    cyc(); cyc();
    rst_n = 1;
    watch(8);
    check("valid_after_rerelease", wf[3], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
